// File: rtl/multi_lane_serializer.sv
// multi_lane_serializer: PORTS independent serial lanes sharing one DIV-cycle bit tick, each with a holding and a shift register; define SER_PARITY_EN to add an even-parity bit to each frame
module multi_lane_serializer #(
  parameter int PORTS = 4,
  parameter int WIDTH = 8,
  parameter int DIV = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS*WIDTH-1:0] in_data,
  input  logic [PORTS-1:0]       in_valid,
  output logic [PORTS-1:0]       in_ready,
  output logic [PORTS-1:0]       serial_out,
  output logic [PORTS-1:0]       busy
);
`ifdef SER_PARITY_EN
  localparam int FL = WIDTH + 3;
`else
  localparam int FL = WIDTH + 2;
`endif
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW = $clog2(FL);
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(FL - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  logic [CW-1:0] cnt;
  logic tick;
  assign tick = cnt == CMAX;
  always_ff @(posedge clk)
    if (!rst) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  for (genvar i = 0; i < PORTS; i++) begin : g_lane
    state_t st, st_n;
    logic full, full_n, so, so_n, rdy;
    logic [WIDTH-1:0] hold, hold_n;
    logic [FL-2:0] sh, sh_n;
    logic [BW-1:0] bc, bc_n;
    always_comb begin
      st_n = st;
      full_n = full;
      hold_n = hold;
      sh_n = sh;
      bc_n = bc;
      so_n = so;
      if (tick && st == SHIFT && bc != BMAX) begin
        so_n = sh[0];
        sh_n = sh >> 1;
        bc_n = bc + 1'b1;
      end else if (tick && full) begin
        st_n = SHIFT;
        so_n = 1'b0;
        full_n = 1'b0;
        bc_n = '0;
`ifdef SER_PARITY_EN
        sh_n = {1'b1, ^hold, hold};
`else
        sh_n = {1'b1, hold};
`endif
      end else if (tick) begin
        st_n = IDLE;
        so_n = 1'b1;
      end
      if (in_valid[i] && rdy) begin
        full_n = 1'b1;
        hold_n = in_data[i*WIDTH +: WIDTH];
      end
    end
    always_ff @(posedge clk)
      if (!rst) begin
        st <= IDLE;
        full <= 1'b0;
        hold <= '0;
        sh <= '0;
        bc <= '0;
        so <= 1'b1;
        rdy <= 1'b0;
      end else begin
        st <= st_n;
        full <= full_n;
        hold <= hold_n;
        sh <= sh_n;
        bc <= bc_n;
        so <= so_n;
        rdy <= !full_n;
      end
    assign serial_out[i] = so;
    assign in_ready[i] = rdy;
    assign busy[i] = st == SHIFT || full;
  end
endmodule

// File: tb/tb_multi_lane_serializer.sv
// tb_multi_lane_serializer: random and directed stimulus against a frame-timeline reference model
module tb_multi_lane_serializer;
  localparam int DIV = 4;
`ifdef SER_PARITY_EN
  localparam int FL = 11;
  localparam logic [31:0] DIV1_EXP = 32'hDFE;
`else
  localparam int FL = 10;
  localparam logic [31:0] DIV1_EXP = 32'h7FE;
`endif
  logic clk = 0;
  logic rst = 0;
  logic [31:0] in_data = '0;
  logic [3:0] in_valid = '0;
  logic [3:0] in_ready, serial_out, busy;
  logic [7:0] d1 = '0;
  logic v1 = 0;
  logic rdy1, ser1, busy1;
  int n_chk = 0, n_pass = 0;
  int k = 0;
  int st_m[4];
  bit hf[4];
  logic [7:0] hw[4], cw[4];
  logic [3:0] e_ser = 4'hF, e_busy = '0, e_rdy = '0;
  multi_lane_serializer #(.PORTS(4), .WIDTH(8), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .serial_out(serial_out), .busy(busy)
  );
  multi_lane_serializer #(.PORTS(1), .WIDTH(8), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1),
    .in_ready(rdy1), .serial_out(ser1), .busy(busy1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
  endtask
  function automatic logic fbit(input logic [7:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
`ifdef SER_PARITY_EN
    if (b == 9) return ^w;
`endif
    return 1'b1;
  endfunction
  task automatic model(input logic r, input logic [3:0] v, input logic [31:0] d);
    if (!r) begin
      k = 0;
      for (int i = 0; i < 4; i++) begin
        st_m[i] = -1;
        hf[i] = 0;
      end
    end else begin
      k++;
      for (int i = 0; i < 4; i++) begin
        bit cap;
        cap = v[i] && k >= 2 && !hf[i];
        if (k % DIV == 0 && !(st_m[i] >= 0 && k - st_m[i] < FL * DIV)) begin
          if (hf[i]) begin
            st_m[i] = k;
            cw[i] = hw[i];
            hf[i] = 0;
          end else st_m[i] = -1;
        end
        if (cap) begin
          hf[i] = 1;
          hw[i] = d[i*8 +: 8];
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      e_ser[i] = st_m[i] >= 0 ? fbit(cw[i], (k - st_m[i]) / DIV) : 1'b1;
      e_busy[i] = st_m[i] >= 0 || hf[i];
      e_rdy[i] = r && k >= 1 && !hf[i];
    end
  endtask
  task automatic step(input logic r, input logic [3:0] v, input logic [31:0] d);
    rst = r;
    in_valid = v;
    in_data = d;
    @(posedge clk);
    model(r, v, d);
    @(negedge clk);
    chk("serial_out", 32'(serial_out), 32'(e_ser));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
  endtask
  task automatic send(input int lane, input logic [7:0] w);
    for (int n = 0; n < 200 && !e_rdy[lane]; n++) step(1, 4'h0, 32'h0);
    step(1, 4'(1 << lane), 32'(w) << (lane * 8));
  endtask
  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1, 4'h0, 32'h0);
  endtask
  initial begin
    logic [31:0] seq1;
    for (int i = 0; i < 4; i++) begin
      st_m[i] = -1;
      hf[i] = 0;
    end
    for (int j = 0; j < 3; j++) step(0, 4'hF, 32'hFFFF_FFFF);
    chk("rst_serial", 32'(serial_out), 32'hF);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    step(1, 4'hF, 32'hFFFF_FFFF);
    send(0, 8'hA5);
    idle(60);
    send(1, 8'h01);
    send(1, 8'h80);
    idle(100);
    for (int n = 0; n < 200 && !(e_rdy[2] && e_rdy[3]); n++) step(1, 4'h0, 32'h0);
    step(1, 4'b1100, {8'h81, 8'h3C, 16'h0});
    idle(60);
    send(0, 8'h33);
    for (int n = 0; n < 200 && st_m[0] < 0; n++) step(1, 4'h0, 32'h0);
    send(0, 8'hC3);
    for (int n = 0; n < 200 && !e_rdy[0]; n++) step(1, 4'h1, 32'h55);
    idle(100);
    send(0, 8'h5A);
    for (int n = 0; n < 400 && !(st_m[0] >= 0 && (k - st_m[0]) / DIV >= 5); n++) step(1, 4'h0, 32'h0);
    step(0, 4'h0, 32'h0);
    chk("midrst_serial", 32'(serial_out), 32'hF);
    chk("midrst_busy", 32'(busy), 32'h0);
    idle(60);
    for (int j = 0; j < 3000; j++) begin
      logic r;
      logic [3:0] v;
      r = $urandom_range(0, 399) != 0;
      v = 4'($urandom & $urandom);
      step(r, v, $urandom);
    end
    idle(120);
    v1 = 1;
    d1 = 8'hFF;
    step(1, 4'h0, 32'h0);
    v1 = 0;
    chk("div1_ready_low", 32'(rdy1), 32'h0);
    seq1 = '0;
    for (int b = 0; b < FL + 1; b++) begin
      step(1, 4'h0, 32'h0);
      seq1[b] = ser1;
    end
    chk("div1_frame", seq1, DIV1_EXP);
    chk("div1_busy_end", 32'(busy1), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multi_lane_serializer.md
MULTI_LANE_SERIALIZER -- requirements
Module: multi_lane_serializer

Interface
REQ-001 SHALL have parameter PORTS, default 4: number of independent serial lanes (min 1).
REQ-002 SHALL have parameter WIDTH, default 8: data bits per word (min 1).
REQ-003 SHALL have parameter DIV, default 10: clock cycles per serial bit period (min 1).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_data  input  PORTS*WIDTH  packed words; lane i at [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  PORTS  per-lane word valid.
REQ-008 SHALL have port in_ready  output  PORTS  per-lane holding register empty.
REQ-009 SHALL have port serial_out  output  PORTS  per-lane registered serial line; idle level 1.
REQ-010 SHALL have port busy  output  PORTS  per-lane frame in progress or word held.

Function
REQ-011 SHALL run one shared bit-tick counter 0..DIV-1, free-running from reset; tick asserts in the cycle the count equals DIV-1; DIV=1 gives tick every cycle.
REQ-012 SHALL transmit per frame: start bit 0, WIDTH data bits LSB first, parity bit (REQ-024 only), stop bit 1.
REQ-013 SHALL give each lane one holding register plus one shift register; in_ready[i] = holding register empty.
REQ-014 SHALL capture in_data lane i into the holding register on an edge with in_valid[i] && in_ready[i]; in_valid while in_ready low SHALL be ignored, with no data captured.
REQ-015 SHALL implement a per-lane FSM with states IDLE and SHIFT; serial_out SHALL change only on tick edges.
REQ-016 In IDLE, on tick with holding register full: serial_out<=0, holding moves to shifter, holding empties, bit counter<=0, go SHIFT.
REQ-017 In SHIFT, on each tick, SHALL drive the next frame bit; after the stop bit has occupied one full bit period, the next tick SHALL start a new frame at once (start bit, no idle gap) if holding is full, else drive 1 and go IDLE.
REQ-018 SHALL keep in_ready low in the transfer cycle; it SHALL rise on the following edge.
REQ-019 Latency: a word captured at edge t SHALL start its start bit on the first tick edge after t while in IDLE.
REQ-020 SHALL hold every bit on serial_out for exactly DIV cycles.
REQ-021 busy[i] SHALL be 1 when state is SHIFT or holding is full, else 0.
REQ-022 SHALL operate lanes independently; lanes loaded before the same tick SHALL emit bit-aligned frames.

Reset
REQ-023 While rst=0 at an edge: tick counter<=0, all FSMs<=IDLE, holding/shift registers emptied, serial_out<=all 1, busy<=0, in_ready<=0; in_ready SHALL be all 1 from the first edge with rst=1. Reset mid-frame SHALL abort the frame and discard held words.

Configuration
REQ-024 With macro SER_PARITY_EN defined, frame SHALL include an even-parity bit (XOR of data bits) after the last data bit, frame length WIDTH+3 bits; without the macro there is no parity bit and frame length is WIDTH+2 bits.

Verification (PORTS=4, WIDTH=8, DIV=4)
REQ-025 SER_PARITY_EN on, lane0 sends 0xA5 -> serial_out[0] = 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles, then 1 idle; busy[0] low after stop bit.
REQ-026 SER_PARITY_EN off, lane1 sends 0x01 then 0x80 immediately when in_ready rises -> 0,1,0,0,0,0,0,0,0,1 then 0,0,0,0,0,0,0,0,1,1 with no idle bit between the frames.
REQ-027 lane2=0x3C and lane3=0x81 captured in the same cycle -> start bits on the same tick edge; frames bit-aligned for their whole length.
REQ-028 holding full and shifting on lane0, in_valid[0]=1 with 0x55 while in_ready[0]=0 -> 0x55 never transmitted; held word transmitted unchanged.
REQ-029 rst=0 for one cycle after 5 bits of a lane0 frame -> next edge serial_out=all 1, busy=0; no remainder of the word transmitted; in_ready=1 one edge later.
REQ-030 DIV=1, lane0 sends 0xFF with parity on -> 0,1,1,1,1,1,1,1,1,0,1 on 11 consecutive cycles.
